instruction_fetch_unit: RTL and testbench

- Sits upstream of the instruction decoder, which feeds opcode/funct3 to the control unit.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instruction, pc, pc+4} to decode over a valid/ready handshake.
- Accepts a redirect from jump/branch resolution, which flushes the FIFO and discards responses already in flight.

---
 rtl/instruction_fetch_unit_pkg.sv | 26 ++
 rtl/instruction_fetch_unit_if.sv | 40 ++++
 rtl/instruction_fetch_unit_fetch_buffer.sv | 59 +++++
 rtl/instruction_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM encoding, the buffered entry layout and fetch-address helpers.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ENTRY_WIDTH = 2 * XLEN;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTRUCTION  = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH_STATE_RUN   = 1'b0,
        FETCH_STATE_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] address);
        return {address[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-side, redirect and decode-side handshake bundle of the fetch unit.
// master is the fetch unit itself; slave is memory plus decode.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic            imem_request_valid;
    logic            imem_request_ready;
    logic [XLEN-1:0] imem_request_address;
    logic            imem_response_valid;
    logic [XLEN-1:0] imem_response_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            instruction_valid;
    logic            instruction_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] instruction_pc;
    logic [XLEN-1:0] instruction_pc_plus_4;
    logic            fetch_misaligned;

    modport master (
        output imem_request_valid, imem_request_address,
        input  imem_request_ready,
        input  imem_response_valid, imem_response_data,
        input  redirect, redirect_pc,
        output instruction_valid, instruction, instruction_pc, instruction_pc_plus_4,
        input  instruction_ready,
        output fetch_misaligned
    );

    modport slave (
        input  imem_request_valid, imem_request_address,
        output imem_request_ready,
        output imem_response_valid, imem_response_data,
        output redirect, redirect_pc,
        input  instruction_valid, instruction, instruction_pc, instruction_pc_plus_4,
        output instruction_ready,
        input  fetch_misaligned
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: issues word requests, buffers in-order responses for decode,
// and on redirect flushes the buffer and drops responses still in flight.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned     BUFFER_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instruction_fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(BUFFER_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    fetch_state_t     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [CW-1:0]    drop_count;
    logic             misaligned_q;

    logic [CW-1:0]    addr_count;
    logic [CW-1:0]    data_count;
    logic             addr_empty;
    logic             addr_full;
    logic             data_empty;
    logic             data_full;
    logic [XLEN-1:0]  response_pc;
    logic [ENTRY_WIDTH-1:0] head_bits;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    logic [OW-1:0]    in_flight;
    logic [OW-1:0]    in_flight_next;
    logic [OW-1:0]    occupancy;
    logic             request_valid;
    logic             accept;
    logic             response_keep;
    logic             decode_valid;
    logic             decode_pop;
    logic             data_push;

    // Outstanding words: those awaiting a pc match plus those already marked for discard.
    assign in_flight      = OW'(addr_count) + OW'(drop_count);
    assign occupancy      = in_flight + OW'(data_count);
    assign in_flight_next = in_flight + OW'(accept) - OW'(bus.imem_response_valid);

    assign request_valid = reset_n && (state == FETCH_STATE_RUN) && !bus.redirect
                        && (occupancy < OW'(BUFFER_DEPTH)) && !addr_full;
    assign accept        = request_valid && bus.imem_request_ready;
    assign response_keep = bus.imem_response_valid && (drop_count == '0)
                        && !bus.redirect && !addr_empty;

    assign decode_valid = !data_empty && !bus.redirect;
    assign decode_pop   = decode_valid && bus.instruction_ready;
    assign data_push    = response_keep && (!data_full || decode_pop);

    assign push_entry = '{pc: response_pc, instruction: bus.imem_response_data};
    assign head       = head_bits;

    // Request addresses queue here at accept and pair with their response data in order.
    fetch_buffer #(.DEPTH(BUFFER_DEPTH), .WIDTH(XLEN)) u_address_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.redirect),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (response_keep),
        .head      (response_pc),
        .count     (addr_count),
        .empty     (addr_empty),
        .full      (addr_full)
    );

    fetch_buffer #(.DEPTH(BUFFER_DEPTH), .WIDTH(ENTRY_WIDTH)) u_fetch_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.redirect),
        .push      (data_push),
        .push_data (push_entry),
        .pop       (decode_pop),
        .head      (head_bits),
        .count     (data_count),
        .empty     (data_empty),
        .full      (data_full)
    );

    // Fetch control FSM; redirect overrides issue, discard and FLUSH exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FETCH_STATE_RUN;
            fetch_pc     <= RESET_PC;
            drop_count   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= bus.redirect && (|bus.redirect_pc[1:0]);
            if (bus.redirect) begin
                fetch_pc   <= align_word(bus.redirect_pc);
                drop_count <= CW'(in_flight_next);
                state      <= (in_flight_next != '0) ? FETCH_STATE_FLUSH : FETCH_STATE_RUN;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (bus.imem_response_valid && (drop_count != '0)) begin
                    drop_count <= drop_count - CW'(1);
                end
                case (state)
                    FETCH_STATE_RUN:   state <= FETCH_STATE_RUN;
                    FETCH_STATE_FLUSH: if (drop_count == '0) state <= FETCH_STATE_RUN;
                    default:           state <= FETCH_STATE_RUN;
                endcase
            end
        end
    end

    assign bus.imem_request_valid    = request_valid;
    assign bus.imem_request_address  = fetch_pc;
    assign bus.instruction_valid     = decode_valid;
    assign bus.instruction           = data_empty ? '0 : head.instruction;
    assign bus.instruction_pc        = data_empty ? '0 : head.pc;
    assign bus.instruction_pc_plus_4 = data_empty ? '0 : head.pc + 32'd4;
    assign bus.fetch_misaligned      = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Cycle-table bench for instruction_fetch_unit with a small in-order memory model.
// Each record gives this cycle's inputs and the outputs expected before the next edge.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    typedef struct {
        logic        rdy;
        logic        men;
        logic        redir;
        logic [31:0] rpc;
        logic        drdy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    logic clk;
    logic reset_n;
    int unsigned n_vec;
    int unsigned n_bad;
    logic [31:0] pend[$];
    vec_t tbl[$];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUFFER_DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a < 32'h10) ? NOP_INSTRUCTION : (a ^ 32'h5A00_0000);
    endfunction

    function automatic vec_t mk(input logic rdy, input logic men, input logic redir,
                                input logic [31:0] rpc, input logic drdy,
                                input logic e_rv, input logic [31:0] e_ra,
                                input logic e_iv, input logic [31:0] e_ipc, input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.men = men; v.redir = redir; v.rpc = rpc; v.drdy = drdy;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic drive_idle();
        bus.imem_request_ready  = 1'b0;
        bus.imem_response_valid = 1'b0;
        bus.imem_response_data  = '0;
        bus.redirect            = 1'b0;
        bus.redirect_pc         = '0;
        bus.instruction_ready   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        n_vec++;
        if (bus.imem_request_valid !== 1'b0 || bus.imem_request_address !== 32'h0 ||
            bus.instruction_valid !== 1'b0 || bus.instruction !== 32'h0 ||
            bus.instruction_pc !== 32'h0 || bus.instruction_pc_plus_4 !== 32'h0 ||
            bus.fetch_misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: rv=%0b ra=%h iv=%0b ins=%h pc=%h pc4=%h mis=%0b, want all zero",
                     tag, bus.imem_request_valid, bus.imem_request_address, bus.instruction_valid,
                     bus.instruction, bus.instruction_pc, bus.instruction_pc_plus_4,
                     bus.fetch_misaligned);
        end
    endtask

    // Drive one cycle at posedge+1, check at negedge, then advance the memory model.
    task automatic apply(input vec_t v, input string tag);
        logic        ok;
        logic        acc;
        logic [31:0] addr;
        logic [31:0] e_ins;
        logic [31:0] e_p4;
        bus.imem_request_ready = v.rdy;
        bus.redirect           = v.redir;
        bus.redirect_pc        = v.rpc;
        bus.instruction_ready  = v.drdy;
        if (v.men && pend.size() > 0) begin
            bus.imem_response_valid = 1'b1;
            bus.imem_response_data  = word_at(pend[0]);
        end else begin
            bus.imem_response_valid = 1'b0;
            bus.imem_response_data  = '0;
        end
        @(negedge clk);
        n_vec++;
        e_ins = word_at(v.e_ipc);
        e_p4  = 32'(v.e_ipc + 32'd4);
        ok = (bus.imem_request_valid === v.e_rv) && (bus.imem_request_address === v.e_ra) &&
             (bus.instruction_valid === v.e_iv) && (bus.fetch_misaligned === v.e_mis);
        if (v.e_iv) begin
            ok = ok && (bus.instruction_pc === v.e_ipc) && (bus.instruction === e_ins) &&
                 (bus.instruction_pc_plus_4 === e_p4);
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got rv=%0b ra=%h iv=%0b pc=%h ins=%h pc4=%h mis=%0b; want rv=%0b ra=%h iv=%0b pc=%h ins=%h pc4=%h mis=%0b",
                     tag, bus.imem_request_valid, bus.imem_request_address, bus.instruction_valid,
                     bus.instruction_pc, bus.instruction, bus.instruction_pc_plus_4,
                     bus.fetch_misaligned, v.e_rv, v.e_ra, v.e_iv, v.e_ipc, e_ins, e_p4, v.e_mis);
        end
        acc  = bus.imem_request_valid && bus.imem_request_ready;
        addr = bus.imem_request_address;
        @(posedge clk);
        #1;
        if (bus.imem_response_valid) void'(pend.pop_front());
        if (acc) pend.push_back(addr);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drive_idle();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;

        // Streaming from reset: requests 0,4,8; first word two cycles after first accept.
        tbl.push_back(mk(1,1,0,0,1, 1,32'h0,  0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h4,  0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h8,  1,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h8,  1,32'h4,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'hC,  0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h10, 1,32'h8,0));
        // Decode stalled six cycles: buffer fills, issue stops, then drains in order.
        tbl.push_back(mk(1,1,0,0,0, 1,32'h10, 1,32'hC,0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1,1,0,0,0, 0,32'h14, 1,32'hC,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h14, 1,32'hC,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h14, 1,32'h10,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h18, 0,32'h0,0));
        // Memory holds responses so two requests are outstanding, then redirect to 0x100.
        tbl.push_back(mk(1,0,0,0,1, 0,32'h1C, 1,32'h14,0));
        tbl.push_back(mk(1,0,0,0,1, 1,32'h1C, 0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,32'h20, 0,32'h0,0));
        tbl.push_back(mk(1,0,1,32'h100,1, 0,32'h20, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h100, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h100, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h100, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h100, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h104, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h108, 1,32'h100,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h108, 1,32'h104,0));
        // Redirect coinciding with a response and a ready decode pop.
        tbl.push_back(mk(1,1,0,0,1, 1,32'h10C, 0,32'h0,0));
        tbl.push_back(mk(1,1,1,32'h200,1, 0,32'h110, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h200, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h204, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h208, 1,32'h200,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h208, 1,32'h204,0));
        // Misaligned redirect to 0x102 with one word in flight.
        tbl.push_back(mk(1,0,1,32'h102,1, 0,32'h20C, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h100, 0,32'h0,1));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h100, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h100, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 1,32'h104, 0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,1, 0,32'h108, 1,32'h100,0));
        // Memory not ready: address and valid hold.
        tbl.push_back(mk(0,1,0,0,0, 1,32'h108, 1,32'h104,0));
        tbl.push_back(mk(0,1,0,0,0, 1,32'h108, 1,32'h104,0));

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_state");
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Address wrap at the top of the 32-bit space.
        apply(mk(1,1,1,32'hFFFF_FFFC,0, 0,32'h108, 0,32'h0,0), "wrap_redirect");
        apply(mk(1,1,0,0,0, 1,32'hFFFF_FFFC, 0,32'h0,0), "wrap_issue_top");
        apply(mk(1,1,0,0,0, 1,32'h0, 0,32'h0,0), "wrap_issue_zero");
        apply(mk(1,1,0,0,0, 0,32'h4, 1,32'hFFFF_FFFC,0), "wrap_pc_plus_4");

        // Reset asserted while decode is stalled on a full buffer.
        reset_n = 1'b0;
        drive_idle();
        pend.delete();
        #1;
        check_reset("reset_mid_stall");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        reset_n = 1'b1;
        apply(mk(0,0,0,0,0, 1,32'h0, 0,32'h0,0), "post_reset_empty");
        apply(mk(1,1,0,0,1, 1,32'h0, 0,32'h0,0), "post_reset_issue");
        apply(mk(1,1,0,0,1, 1,32'h4, 0,32'h0,0), "post_reset_second");
        apply(mk(1,1,0,0,1, 0,32'h8, 1,32'h0,0), "post_reset_first_word");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
